mesh_access_port: RTL and testbench

// - Core-side network interface attached to one Node port (edge port or local tap). Turns

---
 rtl/mesh_access_port_pkg.sv | 22 ++
 rtl/mesh_access_port_if.sv | 40 ++++
 rtl/map_req_fifo.sv | 43 ++++
 rtl/mesh_access_port.sv | 89 ++++++++
 tb/tb_mesh_access_port.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mesh_access_port_pkg.sv
// mesh_access_port_pkg: shared flit widths, request entry layout and FSM states for the mesh access port
//   NET_AW / BANK_AW / DW   router address, bank word address and data widths
//   AW                      global address width {router, bank word}
//   fsmState_t              IDLE=0, ISSUE=1, WAIT=2
//   reqEntry_t              queued request {write, addr, wdata}
//   isReply()               reply flit encoding
package mesh_access_port_pkg;
   localparam int NET_AW  = 4;
   localparam int BANK_AW = 8;
   localparam int DW      = 16;
   localparam int AW      = NET_AW + BANK_AW;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} fsmState_t;
   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } reqEntry_t;
   // A read reply travels as the READ&WRITE combination, which no request ever uses
   function automatic logic isReply(input logic rd, input logic wr);
      return rd && wr;
   endfunction
endpackage

// File: rtl/mesh_access_port_if.sv
// mesh_access_port_if: core request/response channel plus the Node-facing flit In_/Out_ groups
//   req_*    valid/ready request channel (core -> port)
//   resp_*   one-cycle response pulse with held read data (port -> core)
//   busy     work pending in the port
//   *Out     flit driven into the Node In_ group; *In flit taken from the Node Out_ group
//   slave    modport used by the access port, master modport used by the core side
interface mesh_access_port_if;
   import mesh_access_port_pkg::*;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [AW-1:0]     req_addr;
   logic [DW-1:0]     req_wdata;
   logic              resp_valid;
   logic [DW-1:0]     resp_rdata;
   logic              resp_error;
   logic              busy;
   logic [AW-1:0]     destinationAddressOut;
   logic [NET_AW-1:0] requesterAddressOut;
   logic              readOut;
   logic              writeOut;
   logic [DW-1:0]     dataOut;
   logic [AW-1:0]     destinationAddressIn;
   logic [NET_AW-1:0] requesterAddressIn;
   logic              readIn;
   logic              writeIn;
   logic [DW-1:0]     dataIn;
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn,
      output req_ready, resp_valid, resp_rdata, resp_error, busy,
      output destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut
   );
   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn,
      input  req_ready, resp_valid, resp_rdata, resp_error, busy,
      input  destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut
   );
endinterface

// File: rtl/map_req_fifo.sv
// map_req_fifo: synchronous request queue with full/empty flags and a registered pop output
//   clk, reset     clock, synchronous active-high reset (flushes the queue)
//   push/pushData  enqueue; accepted when not full, or when full and popping in the same cycle
//   pop/popData    dequeue; popData loads on pop and holds until the next pop
//   full, empty    occupancy flags
module map_req_fifo
   import mesh_access_port_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  reqEntry_t pushData,
   input  logic      pop,
   output reqEntry_t popData,
   output logic      full,
   output logic      empty
);
   localparam int PW = $clog2(DEPTH);
   reqEntry_t       mem [DEPTH];
   logic [PW-1:0]   wrPtr, rdPtr;
   logic [PW:0]     count;
   logic            wrEn, rdEn;
   assign full  = count == (PW+1)'(DEPTH);
   assign empty = count == '0;
   assign wrEn  = push && (!full || pop);
   assign rdEn  = pop && !empty;
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         popData <= '0;
      end else begin
         if (wrEn) mem[wrPtr] <= pushData;
         wrPtr   <= wrEn ? wrPtr + 1'b1 : wrPtr;
         rdPtr   <= rdEn ? rdPtr + 1'b1 : rdPtr;
         popData <= rdEn ? mem[rdPtr] : popData;
         count   <= count + (PW+1)'(wrEn) - (PW+1)'(rdEn);
      end
   end
endmodule

// File: rtl/mesh_access_port.sv
// mesh_access_port: turns core load/store requests into single-flit mesh packets and collects read replies
//   clk, reset           clock, synchronous active-high reset
//   localRouterAddress   this node's router address (requester field and reply match)
//   bus (slave)          request/response channel and the Node flit In_/Out_ groups
module mesh_access_port
   import mesh_access_port_pkg::*;
#(
   parameter int FIFO_DEPTH     = 2,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRIES    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NET_AW-1:0] localRouterAddress,
   mesh_access_port_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);
   fsmState_t     state, nextState;
   reqEntry_t     head;
   logic          full, empty, pop, inWait, issuing, reply, timeout, giveUp;
   logic          respValid, respError, unusedIn;
   logic [DW-1:0] respRdata;
   logic [TW-1:0] waitCnt;
   logic [RW-1:0] retryCnt;
   // The queue's registered output doubles as the held request for reissues:
   // it only changes on a pop, and pops happen only in IDLE.
   map_req_fifo #(.DEPTH(FIFO_DEPTH)) reqFifo (
      .clk(clk),
      .reset(reset),
      .push(bus.req_valid && !full),
      .pushData({bus.req_write, bus.req_addr, bus.req_wdata}),
      .pop(pop),
      .popData(head),
      .full(full),
      .empty(empty)
   );
   assign inWait  = state == WAIT;
   assign issuing = state == ISSUE;
   assign reply   = isReply(bus.readIn, bus.writeIn) &&
                    bus.destinationAddressIn[AW-1:BANK_AW] == localRouterAddress;
   assign timeout = waitCnt == T_LAST;
   // A reply landing on the timeout cycle wins over giving up
   assign giveUp  = timeout && !reply && retryCnt == R_MAX;
   assign unusedIn = ^{bus.requesterAddressIn, bus.destinationAddressIn[BANK_AW-1:0]};
   always_comb begin
      nextState = state;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            pop       = !empty;
            nextState = empty ? IDLE : ISSUE;
         end
         ISSUE:   nextState = head.write ? IDLE : WAIT;
         WAIT:    nextState = (reply || giveUp) ? IDLE : timeout ? ISSUE : WAIT;
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         waitCnt   <= '0;
         retryCnt  <= '0;
         respValid <= 1'b0;
         respError <= 1'b0;
         respRdata <= '0;
      end else begin
         state     <= nextState;
         waitCnt   <= !inWait ? '0 : timeout ? waitCnt : waitCnt + 1'b1;
         retryCnt  <= !inWait ? retryCnt : (reply || giveUp) ? '0 :
                      (timeout && retryCnt != R_MAX) ? retryCnt + 1'b1 : retryCnt;
         respValid <= inWait && (reply || giveUp);
         respError <= inWait && giveUp;
         respRdata <= inWait && reply ? bus.dataIn : inWait && giveUp ? '0 : respRdata;
      end
   end
   assign bus.req_ready             = !full;
   assign bus.busy                  = !empty || state != IDLE;
   assign bus.resp_valid            = respValid;
   assign bus.resp_error            = respError;
   assign bus.resp_rdata            = respRdata;
   assign bus.destinationAddressOut = issuing ? head.addr : '0;
   assign bus.requesterAddressOut   = issuing ? localRouterAddress : '0;
   assign bus.readOut               = issuing && !head.write;
   assign bus.writeOut              = issuing && head.write;
   assign bus.dataOut               = issuing && head.write ? head.wdata : '0;
endmodule

// File: tb/tb_mesh_access_port.sv
// tb_mesh_access_port: directed scoreboard bench for mesh_access_port
module tb_mesh_access_port;
   import mesh_access_port_pkg::*;
   localparam int TO = 20;
   localparam logic [NET_AW-1:0] LOCAL = 4'd1;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NET_AW-1:0] localAddr = LOCAL;
   int checks = 0, failures = 0, flitCount = 0, respCount = 0, cyc = 0, base = 0;
   logic [33:0] flitQ [$];
   logic [16:0] respQ [$];
   int flitTimes [$];

   mesh_access_port_if bus ();
   mesh_access_port #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(3)) dut (
      .clk(clk),
      .reset(reset),
      .localRouterAddress(localAddr),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every flit and every response pulse is popped against the scoreboard
   always @(negedge clk) begin
      if (bus.readOut || bus.writeOut) begin
         flitTimes.push_back(cyc);
         flitCount++;
         if (flitQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected flit: got dest=%0h data=%0h expected none",
                     bus.destinationAddressOut, bus.dataOut);
         end else
            check("flit", {bus.destinationAddressOut, bus.requesterAddressOut,
                           bus.readOut, bus.writeOut, bus.dataOut}, 64'(flitQ.pop_front()));
      end
      if (bus.resp_valid) begin
         respCount++;
         if (respQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected resp: got rdata=%0h error=%0b expected none",
                     bus.resp_rdata, bus.resp_error);
         end else
            check("resp {rdata,error}", {bus.resp_rdata, bus.resp_error}, 64'(respQ.pop_front()));
      end
   end

   task automatic checkIdle(input string tag);
      check({tag, " req_ready"}, bus.req_ready, 1);
      check({tag, " busy"}, bus.busy, 0);
      check({tag, " resp_valid"}, bus.resp_valid, 0);
      check({tag, " resp_error"}, bus.resp_error, 0);
      check({tag, " resp_rdata"}, bus.resp_rdata, 0);
      check({tag, " flit outputs"}, {bus.destinationAddressOut, bus.requesterAddressOut,
                                     bus.readOut, bus.writeOut, bus.dataOut}, 0);
   endtask

   task automatic sendReq(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      n = 0;
      flitQ.push_back({a, LOCAL, !w, w, w ? d : 16'h0});
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) check("req_ready wait", bus.req_ready, 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic sendReply(input logic [AW-1:0] dest, input logic [DW-1:0] data);
      @(negedge clk);
      bus.destinationAddressIn = dest;
      bus.readIn  = 1'b1;
      bus.writeIn = 1'b1;
      bus.dataIn  = data;
      @(negedge clk);
      bus.destinationAddressIn = '0;
      bus.readIn  = 1'b0;
      bus.writeIn = 1'b0;
      bus.dataIn  = '0;
   endtask

   // Returns on the first rising edge after the n-th flit has been seen
   task automatic waitFlits(input int n);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         k++;
      end while (flitCount < n && k < 200);
      if (flitCount < n) check("flit wait", flitCount, n);
   endtask

   task automatic waitResp(input int n);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         k++;
      end while (respCount < n && k < 400);
      if (respCount < n) check("resp wait", respCount, n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.destinationAddressIn = '0;
      bus.requesterAddressIn   = '0;
      bus.readIn  = 1'b0;
      bus.writeIn = 1'b0;
      bus.dataIn  = '0;
      repeat (3) @(negedge clk);
      checkIdle("reset");
      reset = 1'b0;

      // Load {2,5}, reply 10 cycles after the flit
      sendReq(1'b0, {4'd2, 8'd5}, 16'h0);
      respQ.push_back({16'hBEEF, 1'b0});
      waitFlits(1);
      repeat (9) @(posedge clk);
      sendReply({LOCAL, 8'd0}, 16'hBEEF);
      waitResp(1);

      // Posted store {3,7}: busy drops the cycle after its flit
      sendReq(1'b1, {4'd3, 8'd7}, 16'h1234);
      check("store busy", bus.busy, 1);
      waitFlits(2);
      @(negedge clk);
      check("store busy drop", bus.busy, 0);

      // Three back-to-back loads: one in flight plus two queued fills the queue
      sendReq(1'b0, {4'd2, 8'd1}, 16'h0);
      sendReq(1'b0, {4'd2, 8'd2}, 16'h0);
      sendReq(1'b0, {4'd2, 8'd3}, 16'h0);
      check("full req_ready", bus.req_ready, 0);
      check("full busy", bus.busy, 1);
      for (int i = 0; i < 3; i++) begin
         respQ.push_back({16'(16'h0A01 + i), 1'b0});
         waitFlits(3 + i);
         repeat (2) @(posedge clk);
         sendReply({LOCAL, 8'd0}, 16'(16'h0A01 + i));
      end
      waitResp(4);
      check("ready after drain", bus.req_ready, 1);

      // No reply: 3 reissues spaced TO+1 cycles, then an error response
      base = flitTimes.size();
      sendReq(1'b0, {4'd2, 8'd9}, 16'h0);
      repeat (3) flitQ.push_back(flitQ[$]);
      respQ.push_back({16'h0, 1'b1});
      waitResp(5);
      check("timeout flit count", flitTimes.size() - base, 4);
      if (flitTimes.size() - base == 4)
         for (int i = 1; i < 4; i++)
            check("retry gap", flitTimes[base + i] - flitTimes[base + i - 1], TO + 1);

      // Foreign reply ignored; reply during the retry ISSUE dropped; next reply taken once
      sendReq(1'b0, {4'd2, 8'd4}, 16'h0);
      flitQ.push_back(flitQ[$]);
      respQ.push_back({16'h5555, 1'b0});
      waitFlits(10);
      repeat (3) @(posedge clk);
      sendReply({4'd2, 8'd0}, 16'hDEAD);
      repeat (16) @(posedge clk);
      sendReply({LOCAL, 8'd0}, 16'hAAAA);
      repeat (3) @(posedge clk);
      sendReply({LOCAL, 8'd0}, 16'h5555);
      waitResp(6);
      repeat (10) @(posedge clk);
      check("stale flit count", flitCount, 11);
      check("stale resp count", respCount, 6);

      // Reset while a load waits: everything idles and a late reply is ignored
      sendReq(1'b0, {4'd2, 8'd3}, 16'h0);
      waitFlits(12);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkIdle("mid reset");
      reset = 1'b0;
      @(negedge clk);
      sendReply({LOCAL, 8'd0}, 16'h7777);
      repeat (5) @(posedge clk);
      check("post-reset resp count", respCount, 6);
      @(negedge clk);
      checkIdle("after reset");
      check("flit queue drained", flitQ.size(), 0);
      check("resp queue drained", respQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
